// File: rtl/noc_params.sv
// Shared NoC types: flit format, flit labels, router ports and the downstream VC state.
package noc_params;

    localparam int VC_NUM_DEFAULT      = 2;
    localparam int BUFFER_SIZE_DEFAULT = 8;
    localparam int VC_SIZE             = (VC_NUM_DEFAULT > 1) ? $clog2(VC_NUM_DEFAULT) : 1;
    localparam int DATA_W              = 32;

    typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;
    typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;
    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} vc_state_t;

    typedef struct packed {
        flit_label_t        flit_label;
        logic [VC_SIZE-1:0] vc_id;
        logic [DATA_W-1:0]  data;
    } flit_t;

    function automatic logic is_tail(input flit_label_t label);
        return (label == TAIL) || (label == HEADTAIL);
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Credit count and ownership FSM for one downstream VC; the caller only passes legal events.
module credit_counter
    import noc_params::*;
#(
    parameter int BUFFER_SIZE = BUFFER_SIZE_DEFAULT,
    parameter int CREDIT_W    = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_i,
    input  logic                send_i,
    input  logic                tail_i,
    input  logic                credit_i,
    output vc_state_t           state_o,
    output logic [CREDIT_W-1:0] credit_o
);

    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(BUFFER_SIZE);

    vc_state_t           state_q;
    logic [CREDIT_W-1:0] credit_q, credit_d;

    // A send and a return on the same cycle cancel out.
    always_comb begin
        credit_d = credit_q;
        unique case ({send_i, credit_i})
            2'b10:   credit_d = credit_q - CREDIT_W'(1);
            2'b01:   credit_d = credit_q + CREDIT_W'(1);
            default: credit_d = credit_q;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            credit_q <= CREDIT_MAX;
        end else begin
            credit_q <= credit_d;
            unique case (state_q)
                IDLE:    if (alloc_i)            state_q <= ACTIVE;
                ACTIVE:  if (send_i && tail_i)   state_q <= DRAIN;
                DRAIN:   if (credit_d == CREDIT_MAX) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign state_o  = state_q;
    assign credit_o = credit_q;

endmodule

// File: rtl/output_port_tx.sv
// Output port transmit side: send acceptance, registered link flit, per-VC credit tracking, sticky error.
module output_port_tx
    import noc_params::*;
#(
    parameter int VC_NUM      = VC_NUM_DEFAULT,
    parameter int BUFFER_SIZE = BUFFER_SIZE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  flit_t              flit_i,
    input  logic               valid_i,
    input  logic [VC_NUM-1:0]  alloc_i,
    input  logic               credit_valid_i,
    input  logic [VC_SIZE-1:0] credit_vc_i,
    output flit_t              flit_o,
    output logic               valid_o,
    output logic [VC_NUM-1:0]  is_free_o,
    output logic [VC_NUM-1:0]  has_credit_o,
    output logic               error_o
);

    localparam int CW = $clog2(BUFFER_SIZE + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(BUFFER_SIZE);

    vc_state_t         state_w  [VC_NUM];
    logic [CW-1:0]     credit_w [VC_NUM];

    logic [VC_NUM-1:0] idle_v, active_v, nz_v, full_v;
    logic [VC_NUM-1:0] alloc_v, send_v, credit_v;
    logic              send_vc_ok, credit_vc_ok, alloc_onehot, send_ok;
    logic              alloc_err, credit_err, send_err;

    flit_t             flit_q;
    logic              valid_q, error_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        idle_v       = '0;
        active_v     = '0;
        nz_v         = '0;
        full_v       = '0;
        alloc_v      = '0;
        send_v       = '0;
        credit_v     = '0;
        send_vc_ok   = 32'(flit_i.vc_id) < VC_NUM;
        credit_vc_ok = 32'(credit_vc_i) < VC_NUM;
        alloc_onehot = $onehot(alloc_i);

        for (int v = 0; v < VC_NUM; v++) begin
            idle_v[v]   = (state_w[v] == IDLE);
            active_v[v] = (state_w[v] == ACTIVE);
            nz_v[v]     = (credit_w[v] != '0);
            full_v[v]   = (credit_w[v] == CREDIT_MAX);
        end

        send_ok = valid_i && send_vc_ok && active_v[flit_i.vc_id] && nz_v[flit_i.vc_id];

        // Illegal events are filtered here so the counters only see legal ones.
        for (int v = 0; v < VC_NUM; v++) begin
            send_v[v]   = send_ok && (flit_i.vc_id == VC_SIZE'(v));
            alloc_v[v]  = alloc_i[v] && alloc_onehot && idle_v[v];
            credit_v[v] = credit_valid_i && (credit_vc_i == VC_SIZE'(v)) && !full_v[v];
        end

        alloc_err  = (alloc_i != '0) && (!alloc_onehot || ((alloc_i & ~idle_v) != '0));
        credit_err = credit_valid_i && (!credit_vc_ok || full_v[credit_vc_i]);
        send_err   = valid_i && !send_ok;
    end

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        credit_counter #(
            .BUFFER_SIZE (BUFFER_SIZE),
            .CREDIT_W    (CW)
        ) u_cc (
            .clk      (clk),
            .rst      (rst),
            .alloc_i  (alloc_v[v]),
            .send_i   (send_v[v]),
            .tail_i   (is_tail(flit_i.flit_label)),
            .credit_i (credit_v[v]),
            .state_o  (state_w[v]),
            .credit_o (credit_w[v])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flit_q  <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            valid_q <= send_ok;
            if (send_ok) flit_q <= flit_i;
            error_q <= error_q | alloc_err | credit_err | send_err;
        end
    end

    assign flit_o       = flit_q;
    assign valid_o      = valid_q;
    assign error_o      = error_q;
    assign is_free_o    = idle_v;
    assign has_credit_o = active_v & nz_v;

endmodule

// File: tb/tb_output_port_tx.sv
// Directed bench for output_port_tx: packet flow, credit accounting, protocol errors and async reset.
module tb_output_port_tx;
    import noc_params::*;

    logic               clk = 1'b0;
    logic               rst;
    flit_t              flit_i;
    logic               valid_i;
    logic [1:0]         alloc_i;
    logic               credit_valid_i;
    logic [VC_SIZE-1:0] credit_vc_i;
    flit_t              flit_o;
    logic               valid_o;
    logic [1:0]         is_free_o;
    logic [1:0]         has_credit_o;
    logic               error_o;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    output_port_tx #(.VC_NUM(2), .BUFFER_SIZE(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .flit_i         (flit_i),
        .valid_i        (valid_i),
        .alloc_i        (alloc_i),
        .credit_valid_i (credit_valid_i),
        .credit_vc_i    (credit_vc_i),
        .flit_o         (flit_o),
        .valid_o        (valid_o),
        .is_free_o      (is_free_o),
        .has_credit_o   (has_credit_o),
        .error_o        (error_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i        = 1'b0;
        alloc_i        = 2'b00;
        credit_valid_i = 1'b0;
        credit_vc_i    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
    endtask

    function automatic flit_t mk(input flit_label_t label, input int vc, input logic [31:0] data);
        flit_t f;
        f.flit_label = label;
        f.vc_id      = VC_SIZE'(vc);
        f.data       = data;
        return f;
    endfunction

    task automatic send(input flit_label_t label, input int vc, input logic [31:0] data);
        flit_i  = mk(label, vc, data);
        valid_i = 1'b1;
    endtask

    initial begin
        flit_t       exp_f;
        flit_label_t lbl;

        rst    = 1'b1;
        flit_i = '0;
        idle_inputs();
        #1;
        repeat (2) step();

        check("rst_valid",      64'(valid_o),          64'd0);
        check("rst_flit",       64'(flit_o),           64'd0);
        check("rst_error",      64'(error_o),          64'd0);
        check("rst_is_free",    64'(is_free_o),        64'b11);
        check("rst_has_credit", 64'(has_credit_o),     64'b00);
        check("rst_credit0",    64'(dut.credit_w[0]),  64'd8);
        check("rst_credit1",    64'(dut.credit_w[1]),  64'd8);
        rst = 1'b0;
        step();

        // Allocate VC0.
        alloc_i = 2'b01;
        step();
        idle_inputs();
        check("alloc_is_free",    64'(is_free_o),       64'b10);
        check("alloc_has_credit", 64'(has_credit_o),    64'b01);
        check("alloc_credit0",    64'(dut.credit_w[0]), 64'd8);

        // Eight-flit packet with no credit returns.
        for (int i = 0; i < 8; i++) begin
            lbl = (i == 0) ? HEAD : (i == 7) ? TAIL : BODY;
            send(lbl, 0, 32'h100 + 32'(i));
            step();
            exp_f = mk(lbl, 0, 32'h100 + 32'(i));
            check("pkt_valid", 64'(valid_o), 64'd1);
            check("pkt_flit",  64'(flit_o),  64'(exp_f));
        end
        idle_inputs();
        step();
        check("pkt_valid_after",  64'(valid_o),          64'd0);
        check("pkt_credit0",      64'(dut.credit_w[0]),  64'd0);
        check("pkt_drain_free",   64'(is_free_o[0]),     64'd0);
        check("pkt_drain_credit", 64'(has_credit_o[0]),  64'd0);

        // Return all eight credits; VC0 frees only after the eighth.
        credit_valid_i = 1'b1;
        credit_vc_i    = '0;
        for (int i = 0; i < 7; i++) step();
        check("drain_not_free_7", 64'(is_free_o[0]), 64'd0);
        step();
        idle_inputs();
        check("drain_free_8",  64'(is_free_o[0]),     64'd1);
        check("drain_credit0", 64'(dut.credit_w[0]),  64'd8);
        check("drain_error",   64'(error_o),          64'd0);

        // Drive VC0 to zero credit with body flits, then try one more send.
        alloc_i = 2'b01;
        step();
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            send(BODY, 0, 32'h200 + 32'(i));
            step();
        end
        idle_inputs();
        check("zero_credit0",     64'(dut.credit_w[0]), 64'd0);
        check("zero_has_credit",  64'(has_credit_o),    64'b00);
        check("zero_is_free",     64'(is_free_o),       64'b10);
        send(BODY, 0, 32'h2FF);
        step();
        idle_inputs();
        exp_f = mk(BODY, 0, 32'h207);
        check("nocred_valid",   64'(valid_o),          64'd0);
        check("nocred_error",   64'(error_o),          64'd1);
        check("nocred_credit0", 64'(dut.credit_w[0]),  64'd0);
        check("nocred_flit",    64'(flit_o),           64'(exp_f));

        // Mid-packet async reset with VC0 at credit 3 and a flit in flight.
        credit_valid_i = 1'b1;
        credit_vc_i    = '0;
        repeat (4) step();
        idle_inputs();
        send(BODY, 0, 32'h300);
        step();
        idle_inputs();
        check("pre_rst_valid",   64'(valid_o),          64'd1);
        check("pre_rst_credit0", 64'(dut.credit_w[0]),  64'd3);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_credit0",    64'(dut.credit_w[0]), 64'd8);
        check("midrst_credit1",    64'(dut.credit_w[1]), 64'd8);
        check("midrst_valid",      64'(valid_o),         64'd0);
        check("midrst_error",      64'(error_o),         64'd0);
        check("midrst_is_free",    64'(is_free_o),       64'b11);
        check("midrst_has_credit", 64'(has_credit_o),    64'b00);
        #1;
        rst = 1'b0;
        step();
        check("postrst_valid", 64'(valid_o), 64'd0);

        // VC1 at credit 5: send + return on VC1 together with an allocation of VC0.
        alloc_i = 2'b10;
        step();
        idle_inputs();
        send(HEAD, 1, 32'h400);  step();
        send(BODY, 1, 32'h401);  step();
        send(BODY, 1, 32'h402);  step();
        idle_inputs();
        check("vc1_credit5",    64'(dut.credit_w[1]), 64'd5);
        check("vc1_has_credit", 64'(has_credit_o),    64'b10);
        send(BODY, 1, 32'h403);
        credit_valid_i = 1'b1;
        credit_vc_i    = VC_SIZE'(1);
        alloc_i        = 2'b01;
        step();
        idle_inputs();
        exp_f = mk(BODY, 1, 32'h403);
        check("simul_credit1",    64'(dut.credit_w[1]), 64'd5);
        check("simul_valid",      64'(valid_o),         64'd1);
        check("simul_flit",       64'(flit_o),          64'(exp_f));
        check("simul_is_free",    64'(is_free_o),       64'b00);
        check("simul_has_credit", 64'(has_credit_o),    64'b11);
        check("simul_error",      64'(error_o),         64'd0);

        // Credit return on an IDLE VC already at max credit.
        do_reset();
        credit_valid_i = 1'b1;
        credit_vc_i    = VC_SIZE'(1);
        step();
        idle_inputs();
        check("ovf_credit1", 64'(dut.credit_w[1]), 64'd8);
        check("ovf_error",   64'(error_o),         64'd1);

        // Re-allocation of an ACTIVE VC is ignored but flagged.
        do_reset();
        check("realloc_error_clr", 64'(error_o), 64'd0);
        alloc_i = 2'b01;
        step();
        step();
        idle_inputs();
        check("realloc_is_free",    64'(is_free_o),    64'b10);
        check("realloc_has_credit", 64'(has_credit_o), 64'b01);
        check("realloc_error",      64'(error_o),      64'd1);

        // Non-one-hot allocation is ignored but flagged.
        do_reset();
        alloc_i = 2'b11;
        step();
        idle_inputs();
        check("multi_alloc_is_free", 64'(is_free_o), 64'b11);
        check("multi_alloc_error",   64'(error_o),   64'd1);

        // Tail send and final credit return on the same cycle keep VC1 in DRAIN.
        do_reset();
        alloc_i = 2'b10;
        step();
        idle_inputs();
        send(HEAD, 1, 32'h500);
        step();
        send(TAIL, 1, 32'h501);
        credit_valid_i = 1'b1;
        credit_vc_i    = VC_SIZE'(1);
        step();
        idle_inputs();
        exp_f = mk(TAIL, 1, 32'h501);
        check("tailret_credit1",    64'(dut.credit_w[1]), 64'd7);
        check("tailret_is_free",    64'(is_free_o),       64'b01);
        check("tailret_has_credit", 64'(has_credit_o),    64'b00);
        check("tailret_flit",       64'(flit_o),          64'(exp_f));
        credit_valid_i = 1'b1;
        credit_vc_i    = VC_SIZE'(1);
        step();
        idle_inputs();
        check("tailret_final_credit1", 64'(dut.credit_w[1]), 64'd8);
        check("tailret_final_is_free", 64'(is_free_o),       64'b11);
        check("tailret_final_error",   64'(error_o),         64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
